// File: rtl/mor1kx_cfgrs_pkg.sv
// Shared definitions for the group-0 configuration register SPR slave:
// FSM state encoding, owned-index map and the group-0 constant.
package mor1kx_cfgrs_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StDecode = 2'd1,
        StAck    = 2'd2,
        StDone   = 2'd3
    } cfgrs_state_e;

    // Owned indices span 0..15 of group 0
    localparam int unsigned CfgIdxW = 4;
    localparam logic [4:0]  SprGroupCfg = 5'd0;

    localparam logic [CfgIdxW-1:0] IdxVr       = 4'd0;
    localparam logic [CfgIdxW-1:0] IdxUpr      = 4'd1;
    localparam logic [CfgIdxW-1:0] IdxCpucfgr  = 4'd2;
    localparam logic [CfgIdxW-1:0] IdxDmmucfgr = 4'd3;
    localparam logic [CfgIdxW-1:0] IdxImmucfgr = 4'd4;
    localparam logic [CfgIdxW-1:0] IdxDccfgr   = 4'd5;
    localparam logic [CfgIdxW-1:0] IdxIccfgr   = 4'd6;
    localparam logic [CfgIdxW-1:0] IdxDcfgr    = 4'd7;
    localparam logic [CfgIdxW-1:0] IdxPccfgr   = 4'd8;
    localparam logic [CfgIdxW-1:0] IdxVr2      = 4'd9;
    localparam logic [CfgIdxW-1:0] IdxAvr      = 4'd10;
    localparam logic [CfgIdxW-1:0] IdxWrviol   = 4'd15;

    localparam int unsigned WrviolCntW = 8;

endpackage

// File: rtl/mor1kx_cfgrs_rdmux.sv
// Combinational read mux for the group-0 configuration registers.
// Indices 11..14 read zero; index 15 reads the write-violation counter
// (the top ties the counter to zero when the counter is not built).
module mor1kx_cfgrs_rdmux
    import mor1kx_cfgrs_pkg::*;
#(
    parameter int unsigned OPTION_OPERAND_WIDTH = 32
) (
    input  logic [CfgIdxW-1:0]              idx_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] spr_vr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] spr_upr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] spr_cpucfgr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] spr_dmmucfgr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] spr_immucfgr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] spr_dccfgr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] spr_iccfgr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] spr_dcfgr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] spr_pccfgr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] spr_vr2_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] spr_avr_i,
    input  logic [WrviolCntW-1:0]           wrviol_cnt_i,
    output logic [OPTION_OPERAND_WIDTH-1:0] dat_o
);

    // Select the configuration word addressed by the latched index
    always_comb begin
        dat_o = '0;
        case (idx_i)
            IdxVr:       dat_o = spr_vr_i;
            IdxUpr:      dat_o = spr_upr_i;
            IdxCpucfgr:  dat_o = spr_cpucfgr_i;
            IdxDmmucfgr: dat_o = spr_dmmucfgr_i;
            IdxImmucfgr: dat_o = spr_immucfgr_i;
            IdxDccfgr:   dat_o = spr_dccfgr_i;
            IdxIccfgr:   dat_o = spr_iccfgr_i;
            IdxDcfgr:    dat_o = spr_dcfgr_i;
            IdxPccfgr:   dat_o = spr_pccfgr_i;
            IdxVr2:      dat_o = spr_vr2_i;
            IdxAvr:      dat_o = spr_avr_i;
            IdxWrviol:   dat_o = {{(OPTION_OPERAND_WIDTH-WrviolCntW){1'b0}}, wrviol_cnt_i};
            default:     dat_o = '0;
        endcase
    end

endmodule

// File: rtl/mor1kx_cfgrs_spr_slave.sv
// SPR-bus responder for the group-0 configuration registers. Accesses to
// group 0, index 0..15 are acked with a fixed two-cycle latency; writes are
// discarded and raise a sticky violation flag.
// Optional feature macro: MOR1KX_CFGRS_WRVIOL_CNT_EN adds an 8-bit saturating
// write-violation counter readable at index 15.
module mor1kx_cfgrs_spr_slave
    import mor1kx_cfgrs_pkg::*;
#(
    parameter int unsigned OPTION_SPR_ADDR_WIDTH = 16,
    parameter int unsigned OPTION_OPERAND_WIDTH  = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [OPTION_SPR_ADDR_WIDTH-1:0] spr_bus_addr_i,
    input  logic                             spr_bus_we_i,
    input  logic                             spr_bus_stb_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0]  spr_bus_dat_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0]  spr_vr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0]  spr_upr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0]  spr_cpucfgr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0]  spr_dmmucfgr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0]  spr_immucfgr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0]  spr_dccfgr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0]  spr_iccfgr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0]  spr_dcfgr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0]  spr_pccfgr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0]  spr_vr2_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0]  spr_avr_i,
    output logic                             spr_bus_ack_o,
    output logic [OPTION_OPERAND_WIDTH-1:0]  spr_bus_dat_o,
    output logic                             wr_viol_o
);

    cfgrs_state_e                    state_q, state_d;
    logic [CfgIdxW-1:0]              idx_q;
    logic                            we_q;
    logic [OPTION_OPERAND_WIDTH-1:0] dat_q;
    logic                            wr_viol_q;
    logic [OPTION_OPERAND_WIDTH-1:0] mux_dat;
    logic [WrviolCntW-1:0]           cnt_val;
    logic                            owned;
    logic                            accept;

    // Write data is architecturally ignored for these read-only registers
    logic unused_wdat;
    assign unused_wdat = ^spr_bus_dat_i;

    // Owned: group 0 and every index bit above the 4-bit owned range clear
    assign owned  = (spr_bus_addr_i[OPTION_SPR_ADDR_WIDTH-1:11] == SprGroupCfg) &&
                    (spr_bus_addr_i[10:CfgIdxW] == '0);
    assign accept = (state_q == StIdle) && spr_bus_stb_i && owned;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; DECODE always proceeds, so an aborted strobe still acks
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (accept) state_d = StDecode;
            StDecode: state_d = StAck;
            StAck:    state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Outputs: data is only driven while acking
    always_comb begin
        spr_bus_ack_o = (state_q == StAck);
        spr_bus_dat_o = spr_bus_ack_o ? dat_q : '0;
        wr_viol_o     = wr_viol_q;
    end

    // Access latch, sampled read data and sticky violation flag
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q     <= '0;
            we_q      <= 1'b0;
            dat_q     <= '0;
            wr_viol_q <= 1'b0;
        end else begin
            if (accept) begin
                idx_q <= spr_bus_addr_i[CfgIdxW-1:0];
                we_q  <= spr_bus_we_i;
            end
            if (state_q == StDecode) begin
                dat_q <= we_q ? '0 : mux_dat;
            end
            if ((state_q == StAck) && we_q) begin
                wr_viol_q <= 1'b1;
            end
        end
    end

`ifdef MOR1KX_CFGRS_WRVIOL_CNT_EN
    logic [WrviolCntW-1:0] cnt_q;

    // Saturating count of acked writes to owned indices
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if ((state_q == StAck) && we_q && (cnt_q != {WrviolCntW{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_val = cnt_q;
`else
    assign cnt_val = '0;
`endif

    mor1kx_cfgrs_rdmux #(
        .OPTION_OPERAND_WIDTH (OPTION_OPERAND_WIDTH)
    ) u_rdmux (
        .idx_i          (idx_q),
        .spr_vr_i       (spr_vr_i),
        .spr_upr_i      (spr_upr_i),
        .spr_cpucfgr_i  (spr_cpucfgr_i),
        .spr_dmmucfgr_i (spr_dmmucfgr_i),
        .spr_immucfgr_i (spr_immucfgr_i),
        .spr_dccfgr_i   (spr_dccfgr_i),
        .spr_iccfgr_i   (spr_iccfgr_i),
        .spr_dcfgr_i    (spr_dcfgr_i),
        .spr_pccfgr_i   (spr_pccfgr_i),
        .spr_vr2_i      (spr_vr2_i),
        .spr_avr_i      (spr_avr_i),
        .wrviol_cnt_i   (cnt_val),
        .dat_o          (mux_dat)
    );

endmodule

// File: tb/tb_mor1kx_cfgrs_spr_slave.sv
// Bench for the group-0 configuration register SPR slave. Expected read data
// is queued when an access is launched and checked when the ack appears.
module tb_mor1kx_cfgrs_spr_slave;
    import mor1kx_cfgrs_pkg::*;

    logic        clk;
    logic        rst;
    logic [15:0] addr;
    logic        we;
    logic        stb;
    logic [31:0] wdat;
    logic [31:0] cfg [11];
    logic        ack;
    logic [31:0] rdat;
    logic        wr_viol;

    int total = 0;
    int bad   = 0;
    logic mon_en = 1'b0;
    logic [31:0] exp_q [$];

    mor1kx_cfgrs_spr_slave dut (
        .clk            (clk),
        .rst            (rst),
        .spr_bus_addr_i (addr),
        .spr_bus_we_i   (we),
        .spr_bus_stb_i  (stb),
        .spr_bus_dat_i  (wdat),
        .spr_vr_i       (cfg[0]),
        .spr_upr_i      (cfg[1]),
        .spr_cpucfgr_i  (cfg[2]),
        .spr_dmmucfgr_i (cfg[3]),
        .spr_immucfgr_i (cfg[4]),
        .spr_dccfgr_i   (cfg[5]),
        .spr_iccfgr_i   (cfg[6]),
        .spr_dcfgr_i    (cfg[7]),
        .spr_pccfgr_i   (cfg[8]),
        .spr_vr2_i      (cfg[9]),
        .spr_avr_i      (cfg[10]),
        .spr_bus_ack_o  (ack),
        .spr_bus_dat_o  (rdat),
        .wr_viol_o      (wr_viol)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input logic [31:0] obs, input logic [31:0] expv, input string tag);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Scoreboard side: pop on every ack, and dat_o must be zero otherwise
    always @(negedge clk) begin
        if (mon_en) begin
            if (ack === 1'b1) begin
                total++;
                assert (exp_q.size() != 0) else begin
                    bad++;
                    $error("FAIL spurious_ack observed=ack expected=no_ack");
                end
                if (exp_q.size() != 0) chk(rdat, exp_q.pop_front(), "rd_data");
            end else begin
                chk(rdat, 32'h0, "dat_idle_zero");
            end
        end
    end

    // One access at the minimum 4-cycle spacing with fixed-latency ack checks
    task automatic access(input logic [15:0] a, input logic w, input logic [31:0] d,
                          input logic [31:0] e, input string tag);
        @(negedge clk);
        addr = a; we = w; wdat = d; stb = 1'b1;
        exp_q.push_back(e);
        @(negedge clk);
        chk({31'b0, ack}, 32'd0, {tag, "_no_early_ack"});
        @(negedge clk);
        chk({31'b0, ack}, 32'd1, {tag, "_ack"});
        stb = 1'b0; we = 1'b0;
        @(negedge clk);
        chk({31'b0, ack}, 32'd0, {tag, "_ack_one_cycle"});
        if (w) chk({31'b0, wr_viol}, 32'd1, {tag, "_wr_viol"});
    endtask

    task automatic no_ack(input logic [15:0] a, input string tag);
        @(negedge clk);
        addr = a; we = 1'b0; stb = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk({31'b0, ack}, 32'd0, {tag, "_no_ack"});
            chk(32'(dut.state_q), 32'(StIdle), {tag, "_idle"});
        end
        stb = 1'b0;
    endtask

    logic [31:0] exp15;

    initial begin
        rst = 1'b1; addr = '0; we = 1'b0; stb = 1'b0; wdat = '0;
        for (int i = 0; i < 11; i++) cfg[i] = '0;
        cfg[0] = 32'h1000_0040;
        repeat (3) @(negedge clk);
        chk({31'b0, ack}, 32'd0, "rst_ack");
        chk(rdat, 32'd0, "rst_dat");
        chk({31'b0, wr_viol}, 32'd0, "rst_wr_viol");
        chk(32'(dut.state_q), 32'(StIdle), "rst_state");
        rst = 1'b0;
        mon_en = 1'b1;

        access(16'h0000, 1'b0, 32'h0, 32'h1000_0040, "rd_vr");

        for (int i = 0; i < 11; i++) cfg[i] = 32'hA500_0000 ^ (32'h0101_0101 * (i + 1)) ^ i;
        for (int i = 0; i < 11; i++)
            access(16'(i), 1'b0, 32'h0, 32'hA500_0000 ^ (32'h0101_0101 * (i + 1)) ^ i, "rd_all");
        access(16'h000C, 1'b0, 32'h0, 32'h0, "rd_idx12");

        chk({31'b0, wr_viol}, 32'd0, "viol_before_write");
        access(16'h0002, 1'b1, 32'hFFFF_FFFF, 32'h0, "wr_cpucfgr");
        access(16'h0002, 1'b0, 32'h0, cfg[2], "rd_cpucfgr_after_wr");

        no_ack(16'h0011, "sr");
        no_ack(16'h0800, "grp1");

        for (int i = 0; i < 300; i++) access(16'h0002, 1'b1, 32'(i), 32'h0, "wr_loop");
`ifdef MOR1KX_CFGRS_WRVIOL_CNT_EN
        exp15 = 32'h0000_00FF;
`else
        exp15 = 32'h0;
`endif
        access(16'h000F, 1'b0, 32'h0, exp15, "rd_cnt");

        // Reset while in DECODE: the pending ack is lost
        @(negedge clk);
        addr = 16'h0001; we = 1'b0; stb = 1'b1;
        @(negedge clk);
        chk(32'(dut.state_q), 32'(StDecode), "pre_rst_decode");
        rst = 1'b1; stb = 1'b0;
        @(negedge clk);
        chk({31'b0, ack}, 32'd0, "rst_decode_ack");
        chk(rdat, 32'd0, "rst_decode_dat");
        chk({31'b0, wr_viol}, 32'd0, "rst_decode_wr_viol");
        rst = 1'b0;
        @(negedge clk);
        chk({31'b0, ack}, 32'd0, "post_rst_no_ack");
        access(16'h0009, 1'b0, 32'h0, cfg[9], "rd_after_rst");
`ifdef MOR1KX_CFGRS_WRVIOL_CNT_EN
        access(16'h000F, 1'b0, 32'h0, 32'h0, "cnt_cleared");
`endif

        repeat (3) @(negedge clk);
        chk(32'(exp_q.size()), 32'd0, "queue_drained");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mor1kx_cfgrs_spr_slave.md
# mor1kx_cfgrs_spr_slave

SPR-bus responder that serves mfspr/mtspr accesses to the group-0 configuration registers (VR, UPR, CPUCFGR, DMMUCFGR, IMMUCFGR, DCCFGR, ICCFGR, DCFGR, PCCFGR, VR2, AVR). It consumes the static words produced by mor1kx_cfgrs and returns them over the core's SPR strobe/ack bus with a fixed two-cycle latency. Writes to these read-only registers are acknowledged and discarded, and they are flagged as violations. It sits beside the ctrl stage's SPR bus, in parallel with the other SPR group slaves.

## Interface
- OPTION_SPR_ADDR_WIDTH, 16, SPR address width; bits [15:11] are the group, bits [10:0] are the index.
- OPTION_OPERAND_WIDTH, 32, data width.
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- spr_bus_addr_i  in  16  SPR address
- spr_bus_we_i  in  1  1 = write (mtspr), 0 = read (mfspr)
- spr_bus_stb_i  in  1  access strobe, held until ack
- spr_bus_dat_i  in  32  write data (ignored)
- spr_vr_i, spr_upr_i, spr_cpucfgr_i, spr_dmmucfgr_i, spr_immucfgr_i, spr_dccfgr_i, spr_iccfgr_i, spr_dcfgr_i, spr_pccfgr_i, spr_vr2_i, spr_avr_i  in  32 each  configuration words
- spr_bus_ack_o  out  1  one-cycle acknowledge
- spr_bus_dat_o  out  32  read data, valid only while ack is high, otherwise 0
- wr_viol_o  out  1  sticky flag, set by any write to an owned index

## Operation
- Owned range: group 0, index 0–15. Any other address is never acked by this block and the FSM stays in IDLE.
- Index map:
  - 0 VR, 1 UPR, 2 CPUCFGR, 3 DMMUCFGR, 4 IMMUCFGR, 5 DCCFGR, 6 ICCFGR, 7 DCFGR, 8 PCCFGR, 9 VR2, 10 AVR.
  - 11–14 read 0.
  - 15 reads the violation counter (see Configuration), otherwise 0.
- FSM states: IDLE, DECODE, ACK, DONE.
  - IDLE: on stb & owned address, latch the index and we, then go to DECODE.
  - DECODE: register the read-mux result into the data register (forced to 0 for writes), then go to ACK.
  - ACK: ack_o=1 and dat_o=data register. If the latched we=1, set wr_viol_o. Go to DONE.
  - DONE: stb is ignored for one cycle (the master drops stb the cycle after ack), then go to IDLE.
- Configuration inputs are sampled in DECODE; changes on the inputs after that cycle do not affect the returned data.
- Address or we changes while in DECODE are ignored, because the latched values are used.
- If stb drops in DECODE (an abort), the ack is still issued in ACK. Masters never abort.
- wr_viol_o clears only on rst.

## Timing
- Reset values: state=IDLE, ack_o=0, dat_o=0, wr_viol_o=0, counter=0.
- A stb sampled high at edge N (in IDLE) gives ack_o high during cycle N+2, for exactly one cycle.
- Accesses can be issued back-to-back with a minimum spacing of 4 cycles from stb to stb.
- wr_viol_o rises in the cycle after the write ack.
- An rst asserted in any state returns the FSM to IDLE at the next edge. An ack pending at that point is lost.

## Configuration
- MOR1KX_CFGRS_WRVIOL_CNT_EN
  - Defined: the block includes an 8-bit saturating counter that increments on each write ack to an owned index and stops at 8'hFF. Index 15 reads {24'd0, counter}. Writes to index 15 also count.
  - Undefined: no counter register exists and index 15 reads 0. wr_viol_o is present in both builds.

## Structure
- Shared package mor1kx_cfgrs_pkg holds:
  - the FSM state enum (2 bits);
  - the index localparams (VR=0 … AVR=10, WRVIOL=15);
  - the group-0 constant;
  - the owned-index width (4).
- One combinational sub-module is natural: mor1kx_cfgrs_rdmux. It maps the 4-bit index and the 11 input words (plus the counter) to 32-bit data.

## Test plan
- Read index 0 with spr_vr_i=32'h1000_0040: ack arrives 2 cycles after stb, dat_o=32'h1000_0040, and dat_o=0 in every other cycle.
- Read all indices 0–10 back-to-back at the 4-cycle spacing, each input driven with a unique pattern: every word returns correctly. Index 12 returns 0 with an ack.
- Write index 2 with dat=32'hFFFF_FFFF: ack is issued, wr_viol_o=1 the next cycle, and a later read of index 2 still returns spr_cpucfgr_i.
- Access address 16'h0011 (SR) and 16'h0800 (group 1): no ack for 10 cycles, and the state stays in IDLE.
- With the macro defined, do 300 writes and then read index 15: result is 32'h0000_00FF. With the macro undefined, the same sequence reads 0.
- Assert rst in DECODE: no ack, and all outputs are 0 the next cycle. A new read after reset completes normally.
